// File: rtl/parity_load_arbiter.sv
// Round-robin front end for a shared 8-bit parity accumulator.
// One requester owns the accumulator for a whole packet; the arbiter
// issues the clear at packet start, forwards accepted bytes as ld/d,
// and reports completion or a stall timeout with the owner ID.
module parity_load_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   last,
    input  logic [NREQ*W-1:0] data,
    output logic [NREQ-1:0]   gnt,
    output logic              ld,
    output logic [W-1:0]      d,
    output logic              clr,
    output logic              done,
    output logic              abort,
    output logic [2:0]        owner_id
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state, state_n;
    logic [2:0]      ptr, ptr_n;
    logic [7:0]      stall_cnt, stall_n;
    logic [NREQ-1:0] gnt_n;
    logic            ld_n, clr_n, done_n, abort_n;
    logic [W-1:0]    d_n;
    logic [2:0]      owner_n;

    logic            owner_req, owner_last;
    logic [W-1:0]    owner_data;
    logic            found;
    logic [2:0]      pick;

    // Select the current owner's req/last/byte; everyone else is ignored.
    always_comb begin
        owner_req  = 1'b0;
        owner_last = 1'b0;
        owner_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_id == 3'(i)) begin
                owner_req  = req[i];
                owner_last = last[i];
                owner_data = data[i*W +: W];
            end
        end
    end

    // Round-robin search: first requester at or above ptr, then wrap below it.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (3'(i) >= ptr)) begin
                found = 1'b1;
                pick  = 3'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (3'(i) < ptr)) begin
                found = 1'b1;
                pick  = 3'(i);
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        stall_n = stall_cnt;
        gnt_n   = gnt;
        ld_n    = 1'b0;
        d_n     = d;
        clr_n   = 1'b0;
        done_n  = 1'b0;
        abort_n = 1'b0;
        owner_n = owner_id;
        unique case (state)
            IDLE: begin
                gnt_n = '0;
                if (found) begin
                    state_n = BURST;
                    owner_n = pick;
                    clr_n   = 1'b1;
                    stall_n = '0;
                    ptr_n   = (pick == 3'(NREQ-1)) ? 3'd0 : pick + 3'd1;
                    for (int i = 0; i < NREQ; i++) begin
                        gnt_n[i] = (pick == 3'(i));
                    end
                end
            end
            BURST: begin
                if (owner_req) begin
                    ld_n    = 1'b1;
                    d_n     = owner_data;
                    stall_n = '0;
                    if (owner_last) begin
                        state_n = IDLE;
                        gnt_n   = '0;
                        done_n  = 1'b1;
                    end
                end else if (stall_cnt == 8'(TIMEOUT-1)) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    abort_n = 1'b1;
                    stall_n = '0;
                end else begin
                    stall_n = stall_cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            stall_cnt <= '0;
            gnt       <= '0;
            ld        <= 1'b0;
            d         <= '0;
            clr       <= 1'b0;
            done      <= 1'b0;
            abort     <= 1'b0;
            owner_id  <= '0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            stall_cnt <= stall_n;
            gnt       <= gnt_n;
            ld        <= ld_n;
            d         <= d_n;
            clr       <= clr_n;
            done      <= done_n;
            abort     <= abort_n;
            owner_id  <= owner_n;
        end
    end

endmodule
